// File: rtl/router_pkg.sv
// Shared router definitions: default geometry, controller state encoding and
// the Moore decode that turns a state into its strobe outputs.
package router_pkg;

   localparam int NUM_CH_DEF = 3;
   localparam int ADDR_W_DEF = 2;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      FIFO_FULL_STATE    = 4'd3,
      LOAD_AFTER_FULL    = 4'd4,
      LOAD_PARITY        = 4'd5,
      CHECK_PARITY_ERROR = 4'd6,
      WAIT_TILL_EMPTY    = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;

   typedef struct packed {
      logic write_enb_reg;
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
      logic rst_int_reg;
      logic busy;
      logic drop_state;
   } fsm_out_t;

   // busy stays low only where the source may keep streaming bytes
   function automatic fsm_out_t decode_state(state_t s);
      fsm_out_t o;
      o               = '0;
      o.detect_add    = (s == DECODE_ADDRESS);
      o.lfd_state     = (s == LOAD_FIRST_DATA);
      o.ld_state      = (s == LOAD_DATA);
      o.full_state    = (s == FIFO_FULL_STATE);
      o.laf_state     = (s == LOAD_AFTER_FULL);
      o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
      o.drop_state    = (s == DROP_PACKET);
      o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
      o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA) || (s == DROP_PACKET));
      return o;
   endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Handshake bundle between the router controller and its source / FIFO /
// register neighbours. master drives the controller inputs, slave is the FSM.
interface router_ctrl_fsm_if import router_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) ();

   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] soft_reset;
   logic              parity_done;
   logic              low_pkt_valid;

   logic              write_enb_reg;
   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              rst_int_reg;
   logic              busy;
   logic              drop_state;
   logic [NUM_CH-1:0] dest_sel;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
      input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, busy, drop_state, dest_sel, drop_cnt
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
      output write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, busy, drop_state, dest_sel, drop_cnt
   );

endinterface

// File: rtl/router_ctrl_fsm.sv
// Router write-side controller: decodes the header address, sequences the
// payload/parity load into the selected FIFO and counts dropped packets.
module router_ctrl_fsm import router_pkg::*; #(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                clock,
   input  logic                resetn,
   router_ctrl_fsm_if.slave    bus
);

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] dest_sel_q, dest_sel_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [NUM_CH-1:0] addr_oh;
   logic              addr_ok;
   logic              addr_empty;
   logic              dest_empty;
   logic              dest_soft_rst;
   fsm_out_t          out_c;

   // An address beyond NUM_CH yields an all-zero one-hot, which doubles as
   // the out-of-range detect without a magnitude compare.
   always_comb begin
      addr_oh = '0;
      for (int i = 0; i < NUM_CH; i++) addr_oh[i] = (bus.data_in == ADDR_W'(i));
   end

   assign addr_ok       = |addr_oh;
   assign addr_empty    = |(addr_oh & bus.fifo_empty);
   assign dest_empty    = |(dest_sel_q & bus.fifo_empty);
   assign dest_soft_rst = |(dest_sel_q & bus.soft_reset);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= DECODE_ADDRESS;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DECODE_ADDRESS: begin
            if (bus.pkt_valid) begin
               if (!addr_ok)       state_d = DROP_PACKET;
               else if (addr_empty) state_d = LOAD_FIRST_DATA;
               else                state_d = WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            if (bus.fifo_full) state_d = FIFO_FULL_STATE;
            else               state_d = DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            if (dest_empty) state_d = LOAD_FIRST_DATA;
         end
         DROP_PACKET: begin
            if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
         end
         default: state_d = DECODE_ADDRESS;
      endcase
      // A read-side timeout on our channel aborts the packet wherever it is.
      if (dest_soft_rst && (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET))
         state_d = DECODE_ADDRESS;
   end

   always_comb begin
      out_c             = decode_state(state_q);
      bus.write_enb_reg = out_c.write_enb_reg;
      bus.detect_add    = out_c.detect_add;
      bus.lfd_state     = out_c.lfd_state;
      bus.ld_state      = out_c.ld_state;
      bus.laf_state     = out_c.laf_state;
      bus.full_state    = out_c.full_state;
      bus.rst_int_reg   = out_c.rst_int_reg;
      bus.busy          = out_c.busy;
      bus.drop_state    = out_c.drop_state;
   end

   always_comb begin
      dest_sel_d = dest_sel_q;
      drop_cnt_d = drop_cnt_q;
      if ((state_q == DECODE_ADDRESS) && bus.pkt_valid) begin
         if (addr_ok)           dest_sel_d = addr_oh;
         else if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dest_sel_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         dest_sel_q <= dest_sel_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.dest_sel = dest_sel_q;
   assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: a packet-level model predicts every
// cycle's outputs, and literal checks pin key points of the sequence.
module tb_router_ctrl_fsm;
   import router_pkg::*;

   localparam int NCH = 3;
   localparam int AW  = 2;
   localparam int CW  = 8;

   localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_FF = 3, M_LAF = 4;
   localparam int M_LP = 5, M_CPE = 6, M_WTE = 7, M_DROP = 8;

   // {write_enb, detect_add, lfd, ld, laf, full, rst_int, busy, drop}
   logic [8:0] exp_tbl [9] = '{
      9'b0_1_0_0_0_0_0_0_0,   // decode address
      9'b0_0_1_0_0_0_0_1_0,   // load first data
      9'b1_0_0_1_0_0_0_0_0,   // load data
      9'b0_0_0_0_0_1_0_1_0,   // fifo full
      9'b1_0_0_0_1_0_0_1_0,   // load after full
      9'b1_0_0_0_0_0_0_1_0,   // load parity
      9'b0_0_0_0_0_0_1_1_0,   // check parity error
      9'b0_0_0_0_0_0_0_1_0,   // wait till empty
      9'b0_0_0_0_0_0_0_0_1    // drop packet
   };

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   logic chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   int   m_state = M_DA;
   int   m_dest  = -1;
   int   m_drop  = 0;

   router_ctrl_fsm_if #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) bus ();

   router_ctrl_fsm #(.NUM_CH(NCH), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clock = ~clock;

   function automatic int m_next(int s, int dest);
      int  r;
      int  a;
      logic sr;
      a  = int'(bus.data_in);
      sr = (dest >= 0) && bus.soft_reset[dest];
      r  = s;
      if (s == M_DA) begin
         if (bus.pkt_valid) r = (a >= NCH) ? M_DROP : (bus.fifo_empty[a] ? M_LFD : M_WTE);
      end else if (s == M_LFD) r = M_LD;
      else if (s == M_LD) begin
         if (bus.fifo_full) r = M_FF;
         else if (!bus.pkt_valid) r = M_LP;
      end else if (s == M_FF) begin
         if (!bus.fifo_full) r = M_LAF;
      end else if (s == M_LAF) begin
         r = bus.parity_done ? M_DA : (bus.low_pkt_valid ? M_LP : M_LD);
      end else if (s == M_LP) r = M_CPE;
      else if (s == M_CPE) r = bus.fifo_full ? M_FF : M_DA;
      else if (s == M_WTE) begin
         if (bus.fifo_empty[dest]) r = M_LFD;
      end else if (s == M_DROP) begin
         if (!bus.pkt_valid) r = M_DA;
      end
      if (sr && s != M_DA && s != M_DROP) r = M_DA;
      return r;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_state <= M_DA;
         m_dest  <= -1;
         m_drop  <= 0;
      end else begin
         m_state <= m_next(m_state, m_dest);
         if (m_state == M_DA && bus.pkt_valid) begin
            if (int'(bus.data_in) < NCH) m_dest <= int'(bus.data_in);
            else if (m_drop < 255)       m_drop <= m_drop + 1;
         end
      end
   end

   always @(negedge clock) begin
      logic [8:0]     exp_f, act_f;
      logic [NCH-1:0] exp_d;
      if (chk_en) begin
         exp_f = exp_tbl[m_state];
         exp_d = (m_dest < 0) ? '0 : NCH'(1 << m_dest);
         act_f = {bus.write_enb_reg, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                  bus.full_state, bus.rst_int_reg, bus.busy, bus.drop_state};
         n_tests++;
         if (act_f !== exp_f || bus.dest_sel !== exp_d || int'(bus.drop_cnt) != m_drop) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t flags=%b dest=%b cnt=%0d required flags=%b dest=%b cnt=%0d",
                     $time, act_f, bus.dest_sel, bus.drop_cnt, exp_f, exp_d, m_drop);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      bus.pkt_valid     = 1'b0;
      bus.data_in       = '0;
      bus.fifo_full     = 1'b0;
      bus.fifo_empty    = '0;
      bus.soft_reset    = '0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
      cyc(2);
      chk_en = 1'b1;
      chk("rst_detect_add", int'(bus.detect_add), 1);
      chk("rst_dest_sel", int'(bus.dest_sel), 0);
      chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      resetn = 1'b1;
      cyc(1);

      // basic packet to channel 0
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty = 3'b111;
      cyc(1);
      chk("lfd_state", int'(bus.lfd_state), 1);
      chk("lfd_dest_sel", int'(bus.dest_sel), 1);
      chk("model_pin_lfd", m_state, M_LFD);
      cyc(1);
      chk("ld_state", int'(bus.ld_state), 1);
      chk("ld_busy", int'(bus.busy), 0);
      bus.pkt_valid = 1'b0;
      cyc(1);
      chk("lp_write_enb", int'(bus.write_enb_reg), 1);
      cyc(1);
      chk("cpe_rst_int", int'(bus.rst_int_reg), 1);
      cyc(1);
      chk("back_to_decode", int'(bus.detect_add), 1);

      // full stall, resume with low_pkt_valid
      bus.pkt_valid = 1'b1;
      cyc(2);
      bus.fifo_full = 1'b1;
      cyc(1);
      chk("full_state", int'(bus.full_state), 1);
      chk("full_busy", int'(bus.busy), 1);
      cyc(1);
      bus.fifo_full = 1'b0;
      cyc(1);
      chk("laf_state", int'(bus.laf_state), 1);
      bus.low_pkt_valid = 1'b1;
      cyc(1);
      chk("laf_to_lp", m_state, M_LP);
      bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
      cyc(2);

      // after-full back to LOAD_DATA, then parity_done exit
      bus.pkt_valid = 1'b1;
      cyc(2);
      bus.fifo_full = 1'b1; cyc(1);
      bus.fifo_full = 1'b0; cyc(1);
      cyc(1);
      chk("laf_to_ld", int'(bus.ld_state), 1);
      bus.fifo_full = 1'b1; cyc(1);
      bus.fifo_full = 1'b0; cyc(1);
      bus.parity_done = 1'b1; bus.pkt_valid = 1'b0;
      cyc(1);
      chk("laf_parity_done", int'(bus.detect_add), 1);
      bus.parity_done = 1'b0;

      // busy destination: wait for empty
      bus.data_in = 2'd1; bus.fifo_empty = 3'b101; bus.pkt_valid = 1'b1;
      cyc(1);
      chk("wte_busy", int'(bus.busy), 1);
      chk("wte_dest_sel", int'(bus.dest_sel), 2);
      cyc(1);
      chk("model_pin_wte", m_state, M_WTE);
      bus.fifo_empty = 3'b111;
      cyc(1);
      chk("wte_to_lfd", int'(bus.lfd_state), 1);
      cyc(1);
      bus.soft_reset = 3'b001;
      cyc(1);
      chk("soft_rst_other_ch", int'(bus.ld_state), 1);
      bus.soft_reset = 3'b010;
      cyc(1);
      chk("soft_rst_own_ch", int'(bus.detect_add), 1);

      // soft reset ignored in decode; then abort from FIFO_FULL via CPE
      cyc(1);
      chk("soft_rst_decode_ignored", int'(bus.lfd_state), 1);
      bus.soft_reset = 3'b000;
      cyc(1);
      bus.pkt_valid = 1'b0;
      cyc(1);
      bus.fifo_full = 1'b1;
      cyc(2);
      chk("cpe_to_full", int'(bus.full_state), 1);
      bus.soft_reset = 3'b010;
      cyc(1);
      chk("soft_rst_in_full", int'(bus.detect_add), 1);
      bus.soft_reset = 3'b000; bus.fifo_full = 1'b0;

      // out-of-range address drops
      bus.data_in = 2'd3; bus.pkt_valid = 1'b1;
      cyc(1);
      chk("drop_state", int'(bus.drop_state), 1);
      chk("drop_write_enb", int'(bus.write_enb_reg), 0);
      chk("drop_cnt_1", int'(bus.drop_cnt), 1);
      chk("drop_dest_hold", int'(bus.dest_sel), 2);
      cyc(1);
      chk("drop_cnt_hold", int'(bus.drop_cnt), 1);
      bus.pkt_valid = 1'b0;
      cyc(1);
      chk("drop_exit", int'(bus.detect_add), 1);
      for (int k = 0; k < 256; k++) begin
         bus.pkt_valid = 1'b1; cyc(1);
         bus.pkt_valid = 1'b0; cyc(1);
      end
      chk("drop_cnt_sat", int'(bus.drop_cnt), 255);

      // asynchronous reset mid-packet
      bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
      cyc(2);
      bus.fifo_full = 1'b1;
      cyc(1);
      chk("pre_rst_full", int'(bus.full_state), 1);
      chk("pre_rst_dest", int'(bus.dest_sel), 4);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_detect", int'(bus.detect_add), 1);
      chk("async_rst_dest", int'(bus.dest_sel), 0);
      chk("async_rst_full", int'(bus.full_state), 0);
      chk("async_rst_cnt", int'(bus.drop_cnt), 0);
      bus.pkt_valid = 1'b0; bus.fifo_full = 1'b0;
      cyc(1);
      resetn = 1'b1;
      cyc(3);
      chk("post_rst_no_write", int'(bus.write_enb_reg), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
